// File: rtl/memory_responder.sv
// Byte-addressable data memory answering the CPU MFA/MFC handshake.
// A request is latched when MFA is seen in IDLE. The access is performed
// after WAIT_CYCLES extra edges, and MFC is held until MFA drops.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for MFA; latches the request fields on acceptance
// BUSY  | counting down the programmed wait before the access
// DONE  | access performed, MFC high until MFA is sampled low
module memory_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MFA,
    input  logic        READ_WRITE,
    input  logic        WORD_BYTE,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        AlignErr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic                    accept, access;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             data_q;
    logic                    rw_q, wb_q;

    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [31:0]             acc_data;
    logic                    acc_rw, acc_wb;
    logic                    misaligned, wr_en;
    logic [31:0]             word_rd;

    logic [7:0]              mem [DEPTH];

    // Upper address bits are deliberately ignored so addresses wrap.
    logic                    unused_addr_hi;
    assign unused_addr_hi = ^Address[31:ADDR_WIDTH];

    // With no wait the access happens on the accepting edge, so the live
    // inputs are used; otherwise the latched copies are used.
    assign acc_addr   = (state == IDLE) ? Address[ADDR_WIDTH-1:0] : addr_q;
    assign acc_data   = (state == IDLE) ? DataIn     : data_q;
    assign acc_rw     = (state == IDLE) ? READ_WRITE : rw_q;
    assign acc_wb     = (state == IDLE) ? WORD_BYTE  : wb_q;
    assign misaligned = acc_wb && (acc_addr[1:0] != 2'b00);
    assign wr_en      = access && !acc_rw && !misaligned && Reset;
    assign word_rd    = {mem[{acc_addr[ADDR_WIDTH-1:2], 2'b11}],
                         mem[{acc_addr[ADDR_WIDTH-1:2], 2'b10}],
                         mem[{acc_addr[ADDR_WIDTH-1:2], 2'b01}],
                         mem[{acc_addr[ADDR_WIDTH-1:2], 2'b00}]};

    assign MFC = (state == DONE);

    // Next-state, countdown and access strobe.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (MFA) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        access     = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                if (!MFA) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Capture the request so later input changes cannot disturb it.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr_q <= '0;
            data_q <= '0;
            rw_q   <= 1'b0;
            wb_q   <= 1'b0;
        end else if (accept) begin
            addr_q <= Address[ADDR_WIDTH-1:0];
            data_q <= DataIn;
            rw_q   <= READ_WRITE;
            wb_q   <= WORD_BYTE;
        end
    end

    // Read data and alignment flag update only on DONE entry; AlignErr clears on exit.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            DataOut  <= '0;
            AlignErr <= 1'b0;
        end else if (access) begin
            AlignErr <= misaligned;
            if (acc_rw) begin
                if (misaligned)  DataOut <= '0;
                else if (acc_wb) DataOut <= word_rd;
                else             DataOut <= {24'b0, mem[acc_addr]};
            end
        end else if (state == DONE && !MFA) begin
            AlignErr <= 1'b0;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            if (acc_wb) begin
                mem[{acc_addr[ADDR_WIDTH-1:2], 2'b00}] <= acc_data[7:0];
                mem[{acc_addr[ADDR_WIDTH-1:2], 2'b01}] <= acc_data[15:8];
                mem[{acc_addr[ADDR_WIDTH-1:2], 2'b10}] <= acc_data[23:16];
                mem[{acc_addr[ADDR_WIDTH-1:2], 2'b11}] <= acc_data[31:24];
            end else begin
                mem[acc_addr] <= acc_data[7:0];
            end
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: transaction-level model of the memory and
// handshake timing, a per-cycle compare process, and directed literal checks.
module tb_memory_responder;

    localparam int AW = 10;
    localparam int W  = 2;

    logic        Clk = 1'b0;
    logic        Reset, MFA, READ_WRITE, WORD_BYTE;
    logic [31:0] Address, DataIn, DataOut;
    logic        MFC, AlignErr;

    logic        MFA0, READ_WRITE0, WORD_BYTE0;
    logic [31:0] Address0, DataIn0, DataOut0;
    logic        MFC0, AlignErr0;

    int          checks = 0;
    int          errors = 0;

    logic        exp_mfc  = 1'b0;
    logic        exp_aerr = 1'b0;
    logic [31:0] exp_dout = '0;
    logic [7:0]  mm [1 << AW];

    memory_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset(Reset), .MFA(MFA), .READ_WRITE(READ_WRITE),
        .WORD_BYTE(WORD_BYTE), .Address(Address), .DataIn(DataIn),
        .DataOut(DataOut), .MFC(MFC), .AlignErr(AlignErr)
    );

    memory_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .MFA(MFA0), .READ_WRITE(READ_WRITE0),
        .WORD_BYTE(WORD_BYTE0), .Address(Address0), .DataIn(DataIn0),
        .DataOut(DataOut0), .MFC(MFC0), .AlignErr(AlignErr0)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the main instance against the model.
    always @(negedge Clk) begin
        chk("mfc",  {31'b0, MFC},      {31'b0, exp_mfc});
        chk("aerr", {31'b0, AlignErr}, {31'b0, exp_aerr});
        chk("dout", DataOut,           exp_dout);
    end

    // Model of one access performed on DONE entry.
    task automatic model_access(input logic rw, input logic wb,
                                input logic [31:0] addr, input logic [31:0] data);
        int a;
        a = int'(addr[AW-1:0]);
        exp_mfc = 1'b1;
        if (wb && (a % 4) != 0) begin
            exp_aerr = 1'b1;
            if (rw) exp_dout = '0;
        end else begin
            exp_aerr = 1'b0;
            if (wb) begin
                if (rw) exp_dout = {mm[a+3], mm[a+2], mm[a+1], mm[a]};
                else for (int i = 0; i < 4; i++) mm[a+i] = data[8*i +: 8];
            end else begin
                if (rw) exp_dout = {24'b0, mm[a]};
                else    mm[a] = data[7:0];
            end
        end
    endtask

    // One handshake on the main instance; request inputs are scrambled after acceptance.
    task automatic txn(input logic rw, input logic wb, input logic [31:0] addr,
                       input logic [31:0] data, input bit drop, input int hold);
        @(negedge Clk);
        MFA = 1'b1; READ_WRITE = rw; WORD_BYTE = wb; Address = addr; DataIn = data;
        @(posedge Clk);
        if (W == 0) begin #1; model_access(rw, wb, addr, data); end
        @(negedge Clk);
        Address = $urandom; DataIn = $urandom;
        READ_WRITE = 1'($urandom); WORD_BYTE = 1'($urandom);
        if (drop) MFA = 1'b0;
        if (W > 0) begin
            repeat (W) @(posedge Clk);
            #1; model_access(rw, wb, addr, data);
        end
        if (!drop) begin
            repeat (hold) @(negedge Clk);
            @(negedge Clk);
            MFA = 1'b0;
        end
        @(posedge Clk);
        #1;
        exp_mfc  = 1'b0;
        exp_aerr = 1'b0;
    endtask

    // One handshake on the zero-wait instance with direct timing checks.
    task automatic txn0(input logic rw, input logic wb, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rd);
        @(negedge Clk);
        MFA0 = 1'b1; READ_WRITE0 = rw; WORD_BYTE0 = wb; Address0 = addr; DataIn0 = data;
        chk("w0_mfc_before_edge", {31'b0, MFC0}, 32'd0);
        @(posedge Clk);
        #1;
        chk("w0_mfc_after_accept", {31'b0, MFC0}, 32'd1);
        if (rw) chk("w0_dout", DataOut0, exp_rd);
        @(negedge Clk);
        MFA0 = 1'b0;
        @(posedge Clk);
        #1;
        chk("w0_mfc_drop", {31'b0, MFC0}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_b [4];
        logic [31:0] a;
        logic        rw, wb;

        exp_b[0] = 32'h0000_00EF; exp_b[1] = 32'h0000_00BE;
        exp_b[2] = 32'h0000_00AD; exp_b[3] = 32'h0000_00DE;

        Reset = 1'b0; MFA = 1'b0; READ_WRITE = 1'b0; WORD_BYTE = 1'b0;
        Address = '0; DataIn = '0;
        MFA0 = 1'b0; READ_WRITE0 = 1'b0; WORD_BYTE0 = 1'b0; Address0 = '0; DataIn0 = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;

        // Fill memory so every read has a defined model value.
        for (int i = 0; i < (1 << (AW - 2)); i++) txn(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0, 0);

        txn(1'b0, 1'b1, 32'h010, 32'hDEAD_BEEF, 1'b0, 0);
        txn(1'b1, 1'b1, 32'h010, 32'h0, 1'b0, 1);
        chk("lit_word_rd", DataOut, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            txn(1'b1, 1'b0, 32'h010 + 32'(i), 32'h0, 1'b0, 0);
            chk("lit_byte_rd", DataOut, exp_b[i]);
        end
        txn(1'b0, 1'b0, 32'h012, 32'hFFFF_FF55, 1'b0, 0);
        txn(1'b1, 1'b1, 32'h010, 32'h0, 1'b0, 0);
        chk("lit_byte_wr_merge", DataOut, 32'hDE55_BEEF);

        txn(1'b1, 1'b1, 32'h011, 32'h0, 1'b0, 2);
        chk("lit_misaligned_dout", DataOut, 32'h0);
        chk("lit_aerr_cleared", {31'b0, AlignErr}, 32'd0);
        txn(1'b0, 1'b1, 32'h011, 32'h1111_1111, 1'b0, 0);
        txn(1'b1, 1'b1, 32'h010, 32'h0, 1'b0, 0);
        chk("lit_mem_unchanged", DataOut, 32'hDE55_BEEF);

        txn(1'b0, 1'b1, 32'h400, 32'h1234_5678, 1'b0, 0);
        txn(1'b1, 1'b1, 32'h000, 32'h0, 1'b0, 0);
        chk("lit_wrap", DataOut, 32'h1234_5678);

        txn(1'b0, 1'b1, 32'h020, 32'hA5A5_5A5A, 1'b1, 0);
        txn(1'b1, 1'b1, 32'h020, 32'h0, 1'b1, 0);
        chk("lit_drop_busy_commit", DataOut, 32'hA5A5_5A5A);

        // Reset while BUSY on a write: nothing committed, outputs cleared at once.
        txn(1'b1, 1'b1, 32'h010, 32'h0, 1'b0, 0);
        @(negedge Clk);
        MFA = 1'b1; READ_WRITE = 1'b0; WORD_BYTE = 1'b1; Address = 32'h010; DataIn = 32'h9999_9999;
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        exp_mfc = 1'b0; exp_aerr = 1'b0; exp_dout = '0;
        #1;
        chk("lit_rst_async_dout", DataOut, 32'h0);
        chk("lit_rst_async_mfc", {31'b0, MFC}, 32'd0);
        @(negedge Clk);
        MFA = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        txn(1'b1, 1'b1, 32'h010, 32'h0, 1'b0, 0);
        chk("lit_rst_no_commit", DataOut, 32'hDE55_BEEF);

        for (int n = 0; n < 300; n++) begin
            rw = 1'($urandom);
            wb = 1'($urandom);
            a  = $urandom;
            if (wb && ($urandom_range(0, 3) != 0)) a[1:0] = 2'b00;
            txn(rw, wb, a, $urandom, bit'($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end

        txn0(1'b0, 1'b1, 32'h020, 32'hCAFE_F00D, 32'h0);
        txn0(1'b1, 1'b1, 32'h020, 32'h0, 32'hCAFE_F00D);
        txn0(1'b1, 1'b0, 32'h023, 32'h0, 32'h0000_00CA);

        repeat (2) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
# memory_responder

Byte-addressable data memory acting as the responder side of the CPU memory handshake: the control unit's MAR/MBR datapath raises MFA with READ_WRITE and WORD_BYTE, and this block performs the access after a programmable wait and answers with MFC. It sits between the CPU core (register file, ALU and control unit) and the simulated main memory, and it replaces any zero-latency testbench memory model.

## Interface
- ADDR_WIDTH, 10: byte-address bits actually decoded; memory depth is 2^ADDR_WIDTH bytes.
- WAIT_CYCLES, 2: extra cycles between request acceptance and completion (0 allowed).

- Clk  in  1  single clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MFA  in  1  memory function activate (request), level, held until MFC seen.
- READ_WRITE  in  1  1 = read, 0 = write.
- WORD_BYTE  in  1  1 = 32-bit word, 0 = byte.
- Address  in  32  byte address (from MAR).
- DataIn  in  32  write data (from MBR); byte writes use DataIn[7:0].
- DataOut  out  32  read data to MBR.
- MFC  out  1  memory function complete.
- AlignErr  out  1  misaligned word access flag, valid with MFC.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: on an edge with MFA=1, the block latches Address, DataIn, READ_WRITE, WORD_BYTE.
  - If WAIT_CYCLES=0, it goes directly to DONE and performs the access on that edge.
  - Otherwise it goes to BUSY with cnt=WAIT_CYCLES-1.
- BUSY: each edge, if cnt==0 the access is performed and the state goes to DONE; else cnt decrements.
- DONE: MFC=1. The state holds while MFA=1. On the first edge with MFA=0 it returns to IDLE, with MFC=0 and AlignErr=0.
- Address decode: only Address[ADDR_WIDTH-1:0] is used; upper bits are ignored, so addresses wrap modulo depth.
- Word access, little-endian: byte a holds bits [7:0] and a+3 holds bits [31:24].
  - Requires Address[1:0]==0.
  - If misaligned: no memory write, DataOut<=0, AlignErr<=1 on entry to DONE.
- Byte read: DataOut <= {24'b0, mem[a]}.
- Byte write: mem[a] <= DataIn[7:0]; other bytes are untouched.
- Write accesses leave DataOut unchanged.
- DataOut updates only on entry to DONE for an aligned read or a misaligned word read. It is held stable otherwise, including through IDLE.
- Latched request fields are used for the access; input changes after acceptance are ignored.
- MFA dropping during BUSY does not abort the request. The access completes, DONE is entered, MFC is high for exactly one cycle, then the block returns to IDLE.
- A new request requires MFA to be sampled low at least once (the return-to-IDLE edge); MFA held high across DONE is not a second request.

## Timing
- Reset asserted (low): state=IDLE, MFC=0, DataOut=0, AlignErr=0, cnt=0, immediately and asynchronously.
- Memory contents are not cleared by reset.
- Reset during BUSY aborts the request; no write is committed.
- Latency: request sampled at edge k; MFC and DataOut are valid after edge k+WAIT_CYCLES (WAIT_CYCLES=0 gives MFC after edge k itself).
- MFC falls after the first edge where MFA=0 is sampled in DONE.
- Minimum request period: WAIT_CYCLES+2 cycles (accept, wait, drop).
- A write is committed on the DONE-entry edge; a read issued in the following transaction returns the new data.

## Test plan
- Reset low mid-stream, then release -> MFC=0, DataOut=0, AlignErr=0; a following write+read behaves normally.
- WAIT_CYCLES=2: word write 0xDEADBEEF at 0x010, then word read at 0x010 -> MFC rises exactly 2 edges after MFA sampled, DataOut=0xDEADBEEF.
- Byte reads of 0x010..0x013 after that write -> 0x000000EF, 0x000000BE, 0x000000AD, 0x000000DE. Then byte write 0x55 at 0x012 and word read 0x010 -> 0xDE55BEEF.
- Word read at 0x011 -> MFC=1, AlignErr=1, DataOut=0, memory unchanged. AlignErr=0 after return to IDLE.
- ADDR_WIDTH=10: word write 0x12345678 at 0x400, word read at 0x000 -> 0x12345678 (wrap).
- MFA dropped during BUSY on a write -> MFC high for exactly one cycle, write committed. Separately, Reset asserted in BUSY -> target word unchanged. WAIT_CYCLES=0 build -> MFC after the accepting edge.
